// File: rtl/input_shift_register.sv
// rtl/input_shift_register.sv - receive-side ISR accumulating IN bits and pushing words to the RX FIFO
module input_shift_register #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             shift_en,
  input  logic [4:0]       shift_count,
  input  logic             shiftdir,
  input  logic             autopush,
  input  logic [4:0]       push_thresh,
  input  logic             push_en,
  input  logic             push_iffull,
  input  logic             push_block,
  input  logic             mov,
  input  logic [WIDTH-1:0] mov_in,
  output logic [WIDTH-1:0] mov_out,
  input  logic             fifo_full,
  output logic             fifo_push,
  output logic [WIDTH-1:0] fifo_data,
  output logic             stall,
  output logic [WIDTH-1:0] isr,
  output logic [5:0]       input_shift_counter
);

  logic [5:0]       n;
  logic [5:0]       thr;
  logic [WIDTH-1:0] mask;
  logic [WIDTH-1:0] din;
  logic [WIDTH-1:0] shifted;
  logic [6:0]       sum;
  logic [5:0]       cnt_n;

  logic [WIDTH-1:0] isr_d;
  logic [5:0]       cnt_d;
  logic             push_d;
  logic [WIDTH-1:0] data_d;

  assign mov_out = isr;

  always_comb begin
    n    = (shift_count == 5'd0) ? 6'd32 : {1'b0, shift_count};
    thr  = (push_thresh == 5'd0) ? 6'd32 : {1'b0, push_thresh};
    mask = (n == 6'd32) ? '1 : ((32'd1 << n) - 32'd1);
    din  = in_data & mask;
    if (n == 6'd32) begin
      shifted = in_data;
    end else if (shiftdir) begin
      shifted = (isr >> n) | (din << (6'd32 - n));
    end else begin
      shifted = (isr << n) | din;
    end
    // Counter saturates at a full word rather than wrapping.
    sum   = {1'b0, input_shift_counter} + {1'b0, n};
    cnt_n = (sum > 7'd32) ? 6'd32 : sum[5:0];
  end

  always_comb begin
    isr_d  = isr;
    cnt_d  = input_shift_counter;
    push_d = 1'b0;
    data_d = fifo_data;
    stall  = 1'b0;
    if (mov) begin
      isr_d = mov_in;
      cnt_d = 6'd0;
    end else if (push_en) begin
      if (push_iffull && (input_shift_counter < thr)) begin
        isr_d = isr;
      end else if (!fifo_full) begin
        data_d = isr;
        push_d = 1'b1;
        isr_d  = '0;
        cnt_d  = 6'd0;
      end else if (push_block) begin
        stall = 1'b1;
      end else begin
        // Non-blocking push into a full FIFO drops the word but still clears.
        isr_d = '0;
        cnt_d = 6'd0;
      end
    end else if (shift_en) begin
      if (autopush && (cnt_n >= thr)) begin
        if (fifo_full) begin
          stall = 1'b1;
        end else begin
          data_d = shifted;
          push_d = 1'b1;
          isr_d  = '0;
          cnt_d  = 6'd0;
        end
      end else begin
        isr_d = shifted;
        cnt_d = cnt_n;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      isr                 <= '0;
      input_shift_counter <= 6'd0;
      fifo_push           <= 1'b0;
      fifo_data           <= '0;
    end else begin
      isr                 <= isr_d;
      input_shift_counter <= cnt_d;
      fifo_push           <= push_d;
      fifo_data           <= data_d;
    end
  end

endmodule

// File: tb/tb_input_shift_register.sv
// tb/tb_input_shift_register.sv - directed self-checking bench for input_shift_register
module tb_input_shift_register;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] in_data;
  logic        shift_en;
  logic [4:0]  shift_count;
  logic        shiftdir;
  logic        autopush;
  logic [4:0]  push_thresh;
  logic        push_en;
  logic        push_iffull;
  logic        push_block;
  logic        mov;
  logic [31:0] mov_in;
  logic [31:0] mov_out;
  logic        fifo_full;
  logic        fifo_push;
  logic [31:0] fifo_data;
  logic        stall;
  logic [31:0] isr;
  logic [5:0]  input_shift_counter;

  int total = 0;
  int bad   = 0;

  input_shift_register #(.WIDTH(32)) dut (
    .clk                 (clk),
    .rst                 (rst),
    .in_data             (in_data),
    .shift_en            (shift_en),
    .shift_count         (shift_count),
    .shiftdir            (shiftdir),
    .autopush            (autopush),
    .push_thresh         (push_thresh),
    .push_en             (push_en),
    .push_iffull         (push_iffull),
    .push_block          (push_block),
    .mov                 (mov),
    .mov_in              (mov_in),
    .mov_out             (mov_out),
    .fifo_full           (fifo_full),
    .fifo_push           (fifo_push),
    .fifo_data           (fifo_data),
    .stall               (stall),
    .isr                 (isr),
    .input_shift_counter (input_shift_counter)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] cnt32();
    return {26'd0, input_shift_counter};
  endfunction

  task automatic idle();
    shift_en = 0; push_en = 0; mov = 0; push_iffull = 0; push_block = 0; fifo_full = 0;
  endtask

  logic [7:0] left_bytes [4] = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};

  initial begin
    rst = 0; in_data = 0; shift_count = 0; shiftdir = 0; autopush = 0;
    push_thresh = 0; mov_in = 0;
    idle();
    #3;
    check("rst_isr", isr, 32'h0);
    check("rst_cnt", cnt32(), 32'h0);
    check("rst_push", {31'd0, fifo_push}, 32'h0);
    check("rst_data", fifo_data, 32'h0);
    step();
    #3 rst = 1;
    step();

    // Left shift, autopush off
    shiftdir = 0; shift_count = 8; autopush = 0; shift_en = 1;
    for (int i = 0; i < 4; i++) begin
      in_data = {24'd0, left_bytes[i]};
      step();
    end
    check("left_isr", isr, 32'hA1B2C3D4);
    check("left_cnt", cnt32(), 32'd32);
    in_data = 32'h000000EE;
    step();
    check("left_sat_isr", isr, 32'hB2C3D4EE);
    check("left_sat_cnt", cnt32(), 32'd32);
    check("left_nopush", {31'd0, fifo_push}, 32'h0);

    // Asynchronous reset mid-shift
    #3 rst = 0;
    #1;
    check("arst_isr", isr, 32'h0);
    check("arst_cnt", cnt32(), 32'h0);
    check("arst_push", {31'd0, fifo_push}, 32'h0);
    step();
    check("arst_hold_isr", isr, 32'h0);
    #3 rst = 1;
    #1;
    check("arst_rel_isr", isr, 32'h0);
    check("arst_rel_cnt", cnt32(), 32'h0);
    shift_en = 0;
    step();

    // Right shift with autopush at 16
    shiftdir = 1; autopush = 1; push_thresh = 16; shift_count = 8; shift_en = 1;
    in_data = 32'h11;
    step();
    check("rauto_isr1", isr, 32'h11000000);
    check("rauto_cnt1", cnt32(), 32'd8);
    in_data = 32'h22;
    #1 check("rauto_nostall", {31'd0, stall}, 32'h0);
    step();
    check("rauto_push", {31'd0, fifo_push}, 32'h1);
    check("rauto_data", fifo_data, 32'h22110000);
    check("rauto_isr", isr, 32'h0);
    check("rauto_cnt", cnt32(), 32'h0);
    shift_en = 0;
    step();
    check("rauto_strobe_1cyc", {31'd0, fifo_push}, 32'h0);

    // Autopush against a full FIFO
    shift_en = 1; in_data = 32'h11;
    step();
    in_data = 32'h22; fifo_full = 1;
    for (int i = 0; i < 3; i++) begin
      #1 check("full_stall", {31'd0, stall}, 32'h1);
      step();
      check("full_isr", isr, 32'h11000000);
      check("full_cnt", cnt32(), 32'd8);
      check("full_nopush", {31'd0, fifo_push}, 32'h0);
    end
    fifo_full = 0;
    #1 check("full_free_stall", {31'd0, stall}, 32'h0);
    step();
    check("full_push", {31'd0, fifo_push}, 32'h1);
    check("full_data", fifo_data, 32'h22110000);
    shift_en = 0;
    step();

    // Explicit PUSH variants: isr=5, counter=4, T=8
    autopush = 0; shiftdir = 0; shift_count = 4; push_thresh = 8;
    shift_en = 1; in_data = 32'h5;
    step();
    shift_en = 0;
    check("pset_isr", isr, 32'h5);
    check("pset_cnt", cnt32(), 32'd4);
    push_en = 1; push_iffull = 1;
    #1 check("iffull_stall", {31'd0, stall}, 32'h0);
    step();
    check("iffull_isr", isr, 32'h5);
    check("iffull_cnt", cnt32(), 32'd4);
    check("iffull_push", {31'd0, fifo_push}, 32'h0);
    push_iffull = 0; push_block = 0; fifo_full = 1;
    #1 check("drop_stall", {31'd0, stall}, 32'h0);
    step();
    check("drop_push", {31'd0, fifo_push}, 32'h0);
    check("drop_isr", isr, 32'h0);
    check("drop_cnt", cnt32(), 32'h0);
    push_en = 0; fifo_full = 0; shift_en = 1;
    step();
    shift_en = 0; push_en = 1; push_block = 1; fifo_full = 1;
    #1 check("block_stall", {31'd0, stall}, 32'h1);
    step();
    check("block_isr", isr, 32'h5);
    check("block_nopush", {31'd0, fifo_push}, 32'h0);
    fifo_full = 0;
    #1 check("block_free_stall", {31'd0, stall}, 32'h0);
    step();
    check("block_push", {31'd0, fifo_push}, 32'h1);
    check("block_data", fifo_data, 32'h5);
    check("block_isr_clr", isr, 32'h0);

    // Back-to-back pushes of an empty ISR
    step();
    check("b2b_push", {31'd0, fifo_push}, 32'h1);
    check("b2b_data", fifo_data, 32'h0);

    // Priority: mov beats push and shift
    push_block = 0; mov = 1; mov_in = 32'hDEADBEEF; shift_en = 1; in_data = 32'h7;
    #1 check("prio_stall", {31'd0, stall}, 32'h0);
    step();
    check("prio_isr", isr, 32'hDEADBEEF);
    check("prio_cnt", cnt32(), 32'h0);
    check("prio_push", {31'd0, fifo_push}, 32'h0);
    check("prio_movout", mov_out, 32'hDEADBEEF);

    // Full-width shift (shift_count = 0 encodes 32)
    idle();
    shift_en = 1; shift_count = 0; shiftdir = 1; in_data = 32'h12345678;
    step();
    check("n32_isr", isr, 32'h12345678);
    check("n32_cnt", cnt32(), 32'd32);
    idle();
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
